// File: rtl/hamming_stream.sv
// hamming_stream
//   Streaming, handshaked Hamming-distance engine. An N-bit garbler/evaluator
//   vector pair arrives as CC beats of M = N/CC bits. The block accumulates
//   popcount(g ^ e) over the beats and holds the final distance until the
//   consumer takes it. Vectors are not pipelined: a new vector is accepted
//   only after the previous result has been consumed.
//
//   Optional feature macro: HAMMING_THRESH_EN
//     When defined, adds input thr and output o_match. o_match is registered
//     together with o and reports (distance <= thr), with thr sampled on the
//     last-beat handshake.
//
// Ports
//   clk       in   1           rising-edge clock
//   rst       in   1           asynchronous reset, active-low
//   clr       in   1           synchronous abort (drops partial sum, back to IDLE)
//   in_valid  in   1           beat offered
//   in_ready  out  1           beat accepted when in_valid & in_ready
//   g_input   in   M           garbler beat
//   e_input   in   M           evaluator beat
//   o_valid   out  1           distance valid, held until consumed
//   o_ready   in   1           consumer takes o when o_valid & o_ready
//   o         out  OW          Hamming distance of the completed vector
//   beat_idx  out  BW          beats accepted in the current vector
//   thr       in   OW          (HAMMING_THRESH_EN) match threshold
//   o_match   out  1           (HAMMING_THRESH_EN) distance <= thr
module hamming_stream #(
  parameter  int N  = 8,
  parameter  int CC = 1,
  localparam int M  = N / CC,
  localparam int OW = $clog2(N + 1),
  localparam int BW = $clog2(CC) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  g_input,
  input  logic [M-1:0]  e_input,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [OW-1:0] o,
  output logic [BW-1:0] beat_idx
`ifdef HAMMING_THRESH_EN
 ,input  logic [OW-1:0] thr
 ,output logic          o_match
`endif
);

  localparam int PCW = $clog2(M + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(CC - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  if (N % CC != 0) begin : g_bad_cfg
    $error("hamming_stream: N must be a multiple of CC");
  end

  function automatic logic [PCW-1:0] popcount(input logic [M-1:0] v);
    logic [PCW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < M; i++) begin
      cnt = cnt + PCW'(v[i]);
    end
    return cnt;
  endfunction

  logic [1:0]    state;
  logic [OW-1:0] acc;
  logic [OW-1:0] acc_base;
  logic [OW-1:0] acc_sum;
  logic          beat_hs;
  logic          last_beat;

  // Ready only once out of reset and never while a result is held.
  assign in_ready  = rst && (state != HOLD);
  assign beat_hs   = in_valid && in_ready;
  assign last_beat = (beat_idx == LAST_IDX);
  // The first beat of a vector loads rather than accumulates.
  assign acc_base  = (state == IDLE) ? '0 : acc;
  assign acc_sum   = acc_base + OW'(popcount(g_input ^ e_input));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      acc      <= '0;
      beat_idx <= '0;
      o        <= '0;
      o_valid  <= 1'b0;
`ifdef HAMMING_THRESH_EN
      o_match  <= 1'b0;
`endif
    end else if (clr) begin
      // Abort wins over any handshake this cycle; o keeps its last value.
      state    <= IDLE;
      acc      <= '0;
      beat_idx <= '0;
      o_valid  <= 1'b0;
`ifdef HAMMING_THRESH_EN
      o_match  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, ACC: begin
          if (beat_hs) begin
            acc      <= acc_sum;
            beat_idx <= beat_idx + BW'(1);
            if (last_beat) begin
              o       <= acc_sum;
              o_valid <= 1'b1;
              state   <= HOLD;
`ifdef HAMMING_THRESH_EN
              o_match <= (acc_sum <= thr);
`endif
            end else begin
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (o_ready) begin
            state    <= IDLE;
            acc      <= '0;
            beat_idx <= '0;
            o_valid  <= 1'b0;
`ifdef HAMMING_THRESH_EN
            o_match  <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_stream.sv
// tb_hamming_stream
//   Directed bench for hamming_stream. Two instances share clock and reset:
//   u_dut1 (N=8, CC=1) and u_dut2 (N=8, CC=2). When HAMMING_THRESH_EN is
//   defined the threshold ports are connected and exercised on u_dut1.
module tb_hamming_stream;

  logic clk;
  logic rst;

  // CC=1 instance
  logic       clr1, v1, rdy1, ov1, or1;
  logic [7:0] g1, e1;
  logic [3:0] o1;
  logic [0:0] bi1;
  // CC=2 instance
  logic       clr2, v2, rdy2, ov2, or2;
  logic [3:0] g2, e2;
  logic [3:0] o2;
  logic [1:0] bi2;
`ifdef HAMMING_THRESH_EN
  logic [3:0] thr1, thr2;
  logic       m1, m2;
`endif

  int nvec = 0;
  int nerr = 0;

  hamming_stream #(.N(8), .CC(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr1), .in_valid(v1), .in_ready(rdy1),
    .g_input(g1), .e_input(e1), .o_valid(ov1), .o_ready(or1), .o(o1),
    .beat_idx(bi1)
`ifdef HAMMING_THRESH_EN
   ,.thr(thr1), .o_match(m1)
`endif
  );

  hamming_stream #(.N(8), .CC(2)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr2), .in_valid(v2), .in_ready(rdy2),
    .g_input(g2), .e_input(e2), .o_valid(ov2), .o_ready(or2), .o(o2),
    .beat_idx(bi2)
`ifdef HAMMING_THRESH_EN
   ,.thr(thr2), .o_match(m2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    clr1 = 0; v1 = 0; or1 = 0; g1 = '0; e1 = '0;
    clr2 = 0; v2 = 0; or2 = 0; g2 = '0; e2 = '0;
`ifdef HAMMING_THRESH_EN
    thr1 = '0; thr2 = '0;
`endif

    // Reset state
    tick(); tick();
    check("rst_rdy1", rdy1, 0);
    check("rst_rdy2", rdy2, 0);
    check("rst_o2", o2, 0);
    check("rst_ov2", ov2, 0);
    check("rst_bi2", bi2, 0);
`ifdef HAMMING_THRESH_EN
    check("rst_match1", m1, 0);
`endif
    rst = 1'b1;
    tick();
    check("post_rst_rdy1", rdy1, 1);
    check("post_rst_rdy2", rdy2, 1);

    // CC=1: FF vs 00 -> 8, then A5 vs A5 -> 0
    v1 = 1; g1 = 8'hFF; e1 = 8'h00;
    tick();
    v1 = 0;
    check("t1_o_ff", o1, 8);
    check("t1_ov", ov1, 1);
    check("t1_rdy_hold", rdy1, 0);
    check("t1_bi", bi1, 1);
    or1 = 1;
    tick();
    or1 = 0;
    check("t1_ov_clr", ov1, 0);
    check("t1_rdy_idle", rdy1, 1);
    check("t1_bi_idle", bi1, 0);
    v1 = 1; g1 = 8'hA5; e1 = 8'hA5;
    tick();
    v1 = 0;
    check("t1_o_eq", o1, 0);
    check("t1_ov2", ov1, 1);
    or1 = 1;
    tick();
    or1 = 0;

    // CC=2: (F,0), 3-cycle gap, (3,0) -> 6
    v2 = 1; g2 = 4'hF; e2 = 4'h0;
    tick();
    v2 = 0;
    check("t2_bi_first", bi2, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_bi_gap", bi2, 1);
      check("t2_ov_gap", ov2, 0);
    end
    v2 = 1; g2 = 4'h3; e2 = 4'h0;
    tick();
    check("t2_o", o2, 6);
    check("t2_ov", ov2, 1);
    check("t2_bi_full", bi2, 2);

    // Backpressure: a beat stays offered while the result is held
    g2 = 4'hF; e2 = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_o_stable", o2, 6);
      check("t3_ov_stable", ov2, 1);
      check("t3_rdy_hold", rdy2, 0);
    end
    v2 = 0; or2 = 1;
    tick();
    or2 = 0;
    check("t3_ov_done", ov2, 0);
    check("t3_rdy_idle", rdy2, 1);
    check("t3_bi_idle", bi2, 0);

    // clr after one beat, and clr with a beat offered the same cycle
    v2 = 1; g2 = 4'hF; e2 = 4'h0;
    tick();
    v2 = 0;
    check("t4_bi_one", bi2, 1);
    clr2 = 1;
    tick();
    check("t4_bi_clr", bi2, 0);
    check("t4_o_kept", o2, 6);
    check("t4_rdy_clr", rdy2, 1);
    v2 = 1;
    tick();
    check("t4_bi_discard", bi2, 0);
    clr2 = 0; g2 = 4'h1; e2 = 4'h0;
    tick();
    check("t4_bi_fresh", bi2, 1);
    tick();
    v2 = 0;
    check("t4_o", o2, 2);
    check("t4_ov", ov2, 1);
    or2 = 1;
    tick();
    or2 = 0;

    // Async reset while holding o=5
    v2 = 1; g2 = 4'hF; e2 = 4'h0;
    tick();
    g2 = 4'h1;
    tick();
    v2 = 0;
    check("t5_o_pre", o2, 5);
    #2 rst = 1'b0;
    #1;
    check("t5_o_async", o2, 0);
    check("t5_ov_async", ov2, 0);
    check("t5_bi_async", bi2, 0);
    check("t5_rdy_async", rdy2, 0);
    tick();
    rst = 1'b1;
    tick();
    check("t5_rdy_release", rdy2, 1);

`ifdef HAMMING_THRESH_EN
    // Threshold compare: 3 <= 3 matches, 4 <= 3 does not
    thr1 = 4'd3;
    v1 = 1; g1 = 8'h07; e1 = 8'h00;
    tick();
    v1 = 0; thr1 = 4'd0;
    check("t6_o3", o1, 3);
    check("t6_match3", m1, 1);
    or1 = 1;
    tick();
    or1 = 0;
    check("t6_match_clr", m1, 0);
    thr1 = 4'd3;
    v1 = 1; g1 = 8'h0F; e1 = 8'h00;
    tick();
    v1 = 0;
    check("t6_o4", o1, 4);
    check("t6_match4", m1, 0);
    or1 = 1;
    tick();
    or1 = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
